hex8_loader: RTL



---
 rtl/hex8_pkg.sv | 17 +
 rtl/hex8_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/hex8_pkg.sv
// rtl/hex8_pkg.sv - shared hex8 types and constants for the program loader
package hex8_pkg;

    localparam int HEX8_ADDR_W = 8;

    localparam logic [7:0] SYNC_LOAD_DEFAULT = 8'hA5;
    localparam logic [7:0] SYNC_RUN_DEFAULT  = 8'h5A;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_ADDR = 3'd1,
        LD_LEN  = 3'd2,
        LD_DATA = 3'd3,
        LD_CSUM = 3'd4
    } hex8_ld_state_t;

endpackage

// File: rtl/hex8_loader.sv
// rtl/hex8_loader.sv - framed byte-stream loader for hex8 program memory
// Optional CSUM byte and sticky err flag are enabled by HEX8_LOADER_CHECKSUM_EN.
module hex8_loader
    import hex8_pkg::*;
#(
    parameter logic [7:0] SYNC_LOAD = SYNC_LOAD_DEFAULT,
    parameter logic [7:0] SYNC_RUN  = SYNC_RUN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [HEX8_ADDR_W-1:0] mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic                   err,
    output logic [7:0]             frames_ok
);

    hex8_ld_state_t         state, state_n;
    logic [HEX8_ADDR_W-1:0] addr_ptr, addr_ptr_n;
    logic [8:0]             remaining, remaining_n;
    logic                   mem_we_n;
    logic [HEX8_ADDR_W-1:0] mem_addr_n;
    logic [7:0]             mem_wdata_n;
    logic                   cpu_reset_n;
    logic [7:0]             frames_ok_n;
    logic                   accept;

`ifdef HEX8_LOADER_CHECKSUM_EN
    logic [7:0] csum, csum_n;
    logic       err_n;
`endif

    assign accept = in_valid & in_ready;

    always_comb begin
        state_n     = state;
        addr_ptr_n  = addr_ptr;
        remaining_n = remaining;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        cpu_reset_n = cpu_reset;
        frames_ok_n = frames_ok;
`ifdef HEX8_LOADER_CHECKSUM_EN
        csum_n      = csum;
        err_n       = err;
`endif
        if (accept) begin
            case (state)
                LD_IDLE: begin
                    // A load always parks the core, even if it is running.
                    if (in_data == SYNC_LOAD) begin
                        state_n     = LD_ADDR;
                        cpu_reset_n = 1'b1;
                    end else if (in_data == SYNC_RUN && !err) begin
                        cpu_reset_n = 1'b0;
                    end
                end
                LD_ADDR: begin
                    addr_ptr_n = in_data;
                    state_n    = LD_LEN;
`ifdef HEX8_LOADER_CHECKSUM_EN
                    csum_n     = in_data;
`endif
                end
                LD_LEN: begin
                    remaining_n = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    state_n     = LD_DATA;
`ifdef HEX8_LOADER_CHECKSUM_EN
                    csum_n      = csum + in_data;
`endif
                end
                LD_DATA: begin
                    mem_we_n    = 1'b1;
                    mem_addr_n  = addr_ptr;
                    mem_wdata_n = in_data;
                    addr_ptr_n  = addr_ptr + 1'b1;
                    remaining_n = remaining - 9'd1;
`ifdef HEX8_LOADER_CHECKSUM_EN
                    csum_n      = csum + in_data;
                    if (remaining == 9'd1) begin
                        state_n = LD_CSUM;
                    end
`else
                    if (remaining == 9'd1) begin
                        state_n     = LD_IDLE;
                        frames_ok_n = frames_ok + 8'd1;
                    end
`endif
                end
`ifdef HEX8_LOADER_CHECKSUM_EN
                LD_CSUM: begin
                    state_n = LD_IDLE;
                    csum_n  = csum + in_data;
                    if (csum_n == 8'd0) begin
                        frames_ok_n = frames_ok + 8'd1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
`endif
                default: state_n = LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LD_IDLE;
            addr_ptr  <= '0;
            remaining <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            frames_ok <= '0;
        end else begin
            state     <= state_n;
            addr_ptr  <= addr_ptr_n;
            remaining <= remaining_n;
            in_ready  <= 1'b1;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            cpu_reset <= cpu_reset_n;
            busy      <= (state_n != LD_IDLE);
            frames_ok <= frames_ok_n;
        end
    end

`ifdef HEX8_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= '0;
            err  <= 1'b0;
        end else begin
            csum <= csum_n;
            err  <= err_n;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
